// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI memory-read frame controller.
// State encoding is fixed so debug captures decode the same across builds.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_LEN_W      = 16;

endpackage

// File: rtl/spi_mem_rd_ctrl_if.sv
// Frame-source and SPI memory-read signal bundle for spi_mem_rd_ctrl.
// Handshake: src_frame_rdy, src_rd_req, src_data_vld, mem_rd_ena and mem_ena_out are
// single-cycle pulses with no back-pressure; each src_rd_req gets exactly one
// src_data_vld later, in order, and each mem_rd_ena gets one mem_ena_out next cycle.
interface spi_mem_rd_ctrl_if
   import spi_pkg::*;
#(
   parameter int LEN_W = DEF_LEN_W
);
   logic             src_frame_rdy;
   logic [LEN_W-1:0] src_frame_len;
   logic             src_rd_req;
   logic [7:0]       src_data;
   logic             src_data_vld;
   logic             mem_rd_ena;
   logic [7:0]       mem_data_out;
   logic             mem_ena_out;

   modport master (
      input  src_frame_rdy, src_frame_len, src_data, src_data_vld, mem_rd_ena,
      output src_rd_req, mem_data_out, mem_ena_out
   );

   modport slave (
      output src_frame_rdy, src_frame_len, src_data, src_data_vld, mem_rd_ena,
      input  src_rd_req, mem_data_out, mem_ena_out
   );
endinterface

// File: rtl/spi_rd_fifo.sv
// Small prefetch FIFO with a registered head output updated on pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            dout   <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/spi_mem_rd_ctrl.sv
// Frame read sequencer: credit-limited prefetch from the byte source into a FIFO,
// one byte served per SPI mem_rd_ena, interrupt held while a frame is pending.
module spi_mem_rd_ctrl
   import spi_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LEN_W      = DEF_LEN_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   spi_mem_rd_ctrl_if.master             bus,
   input  logic                          abort,
   input  logic                          flag_clr,
   output logic                          int_o,
   output logic [LEN_W-1:0]              bytes_left,
   output logic                          underrun,
   output logic                          frame_lost,
   output state_t                        state,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0]   DEPTH_L = FIFO_DEPTH[CNT_W:0];
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   state_t           state_next;
   logic [LEN_W-1:0] fetch_left, fetch_left_next, bytes_left_next;
   logic [CNT_W-1:0] outstanding, outstanding_next;
   logic             abort_act, req, rsp, push, pop, fifo_empty, start;
   logic             underrun_set, lost_set, from_fifo, mem_ena_q;
   logic [7:0]       fifo_dout;

   assign abort_act    = abort && (state != IDLE);
   assign fifo_empty   = (fifo_count == '0);
   assign rsp          = bus.src_data_vld && (outstanding != '0);
   assign push         = rsp && (state != FLUSH) && !abort_act;
   assign pop          = bus.mem_rd_ena && !fifo_empty && !abort_act;
   assign start        = (state == IDLE) && bus.src_frame_rdy && (bus.src_frame_len != '0);
   assign underrun_set = bus.mem_rd_ena && fifo_empty && !abort_act &&
                         ((state == FETCH) || (state == DRAIN));
   assign lost_set     = bus.src_frame_rdy && (state != IDLE);
   // Credit: bytes buffered plus bytes in flight never exceed the FIFO depth.
   assign req = (state == FETCH) && !abort_act && (fetch_left != '0) &&
                (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_L);

   always_comb begin
      state_next       = state;
      fetch_left_next  = fetch_left;
      bytes_left_next  = bytes_left;
      outstanding_next = outstanding;
      if (req && !rsp)      outstanding_next = outstanding + CNT_ONE;
      else if (!req && rsp) outstanding_next = outstanding - CNT_ONE;
      if (req) fetch_left_next = fetch_left - LEN_ONE;
      if (pop) bytes_left_next = bytes_left - LEN_ONE;
      case (state)
         IDLE: if (start) begin
            fetch_left_next = bus.src_frame_len;
            bytes_left_next = bus.src_frame_len;
            state_next      = FETCH;
         end
         FETCH: begin
            if (abort_act)                   state_next = FLUSH;
            else if (fetch_left_next == '0)  state_next = DRAIN;
         end
         // Looking at next-cycle counts lets int_o drop the cycle after the last pop.
         DRAIN: begin
            if (abort_act) state_next = FLUSH;
            else if ((bytes_left_next == '0) && (outstanding_next == '0)) state_next = IDLE;
         end
         FLUSH: if (outstanding_next == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort_act) begin
         fetch_left_next = '0;
         bytes_left_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         fetch_left  <= '0;
         bytes_left  <= '0;
         outstanding <= '0;
         mem_ena_q   <= 1'b0;
         from_fifo   <= 1'b0;
         underrun    <= 1'b0;
         frame_lost  <= 1'b0;
      end else begin
         state       <= state_next;
         fetch_left  <= fetch_left_next;
         bytes_left  <= bytes_left_next;
         outstanding <= outstanding_next;
         mem_ena_q   <= bus.mem_rd_ena;
         if (bus.mem_rd_ena) from_fifo <= pop;
         if (flag_clr)          underrun <= 1'b0;
         else if (underrun_set) underrun <= 1'b1;
         if (flag_clr)      frame_lost <= 1'b0;
         else if (lost_set) frame_lost <= 1'b1;
      end
   end

   // The FIFO head register holds the last popped byte; from_fifo picks it or 0x00.
   assign bus.mem_data_out = from_fifo ? fifo_dout : 8'h00;
   assign bus.mem_ena_out  = mem_ena_q;
   assign bus.src_rd_req   = req;
   assign int_o            = (state == FETCH) || (state == DRAIN);

   spi_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (abort_act),
      .din     (bus.src_data),
      .dout    (fifo_dout),
      .count   (fifo_count)
   );
endmodule

// File: tb/tb_spi_mem_rd_ctrl.sv
// Directed bench for spi_mem_rd_ctrl: table of plain frames plus hand sequences
// for credit limit, underrun, lost frame, abort and idle/zero-length corners.
module tb_spi_mem_rd_ctrl;
   import spi_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int LEN_W      = 16;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             abort, flag_clr;
   logic             int_o, underrun, frame_lost;
   logic [LEN_W-1:0] bytes_left;
   state_t           state;
   logic [CNT_W-1:0] fifo_count;

   spi_mem_rd_ctrl_if #(.LEN_W(LEN_W)) bus ();

   spi_mem_rd_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .abort      (abort),
      .flag_clr   (flag_clr),
      .int_o      (int_o),
      .bytes_left (bytes_left),
      .underrun   (underrun),
      .frame_lost (frame_lost),
      .state      (state),
      .fifo_count (fifo_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- byte source model ----------------
   int         src_lat   = 2;
   logic [7:0] src_first = 8'h00;
   int         src_base  = 0;
   int         req_total = 0;
   int         due_q[$];
   logic [7:0] dat_q[$];

   always @(negedge clk) begin
      if (!reset_n) begin
         due_q.delete();
         dat_q.delete();
         bus.src_data_vld = 1'b0;
         bus.src_data     = 8'h00;
      end else begin
         if (bus.src_rd_req) begin
            due_q.push_back(cyc + src_lat);
            dat_q.push_back(src_first + 8'(req_total - src_base));
            req_total++;
         end
         if (due_q.size() != 0 && due_q[0] == cyc) begin
            bus.src_data_vld = 1'b1;
            bus.src_data     = dat_q.pop_front();
            void'(due_q.pop_front());
         end else begin
            bus.src_data_vld = 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_frame(input int len, input int lat, input logic [7:0] first);
      src_lat   = lat;
      src_first = first;
      src_base  = req_total;
      for (int k = 0; k < len; k++) exp_q.push_back(first + 8'(k));
      bus.src_frame_len = LEN_W'(len);
      bus.src_frame_rdy = 1'b1;
      tick(1);
      bus.src_frame_rdy = 1'b0;
      check("int_o_start", int_o, 1);
      check("bytes_left_start", bytes_left, len);
   endtask

   task automatic read_one(input logic exp_int);
      logic [7:0] exp;
      exp = 8'h00;
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      bus.mem_rd_ena = 1'b1;
      tick(1);
      bus.mem_rd_ena = 1'b0;
      check("mem_ena_out", bus.mem_ena_out, 1);
      check("mem_data_out", bus.mem_data_out, exp);
      check("int_o_read", int_o, exp_int);
   endtask

   task automatic read_frame(input int len, input int gap);
      for (int k = 0; k < len; k++) begin
         read_one(k != len - 1);
         check("bytes_left_read", bytes_left, len - 1 - k);
         tick(gap - 1);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         len;
      int         lat;
      int         gap;
      logic [7:0] first;
      logic [7:0] exp_last;
   } frame_vec_t;

   frame_vec_t vecs[4];

   initial begin
      vecs[0] = '{5, 2, 4, 8'h11, 8'h15};
      vecs[1] = '{1, 3, 6, 8'hA0, 8'hA0};
      vecs[2] = '{8, 1, 3, 8'hF8, 8'hFF};
      vecs[3] = '{6, 4, 5, 8'h01, 8'h06};

      reset_n           = 1'b0;
      abort             = 1'b0;
      flag_clr          = 1'b0;
      bus.src_frame_rdy = 1'b0;
      bus.src_frame_len = '0;
      bus.mem_rd_ena    = 1'b0;
      tick(3);
      check("rst_state", state, IDLE);
      check("rst_int_o", int_o, 0);
      reset_n = 1'b1;
      tick(1);
      check("rst_bytes_left", bytes_left, 0);
      check("rst_underrun", underrun, 0);
      check("rst_frame_lost", frame_lost, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_mem_ena_out", bus.mem_ena_out, 0);
      check("rst_mem_data_out", bus.mem_data_out, 0);
      check("rst_src_rd_req", bus.src_rd_req, 0);

      // plain frames
      for (int v = 0; v < 4; v++) begin
         start_frame(vecs[v].len, vecs[v].lat, vecs[v].first);
         tick(vecs[v].lat + 6);
         read_frame(vecs[v].len, vecs[v].gap);
         check("tbl_last_held", bus.mem_data_out, vecs[v].exp_last);
         check("tbl_mem_ena_low", bus.mem_ena_out, 0);
         check("tbl_reqs", req_total - src_base, vecs[v].len);
         check("tbl_state", state, IDLE);
         check("tbl_underrun", underrun, 0);
      end

      // credit limit: no reads, only FIFO_DEPTH requests go out
      start_frame(10, 2, 8'h80);
      tick(15);
      check("credit_reqs", req_total - src_base, 4);
      check("credit_fifo_count", fifo_count, 4);
      check("credit_state", state, FETCH);
      check("credit_bytes_left", bytes_left, 10);
      read_frame(10, 4);
      check("credit_reqs_all", req_total - src_base, 10);
      check("credit_state_end", state, IDLE);

      // underrun: read before the slow source answers
      start_frame(3, 8, 8'h30);
      bus.mem_rd_ena = 1'b1;
      tick(1);
      bus.mem_rd_ena = 1'b0;
      check("ur_mem_ena_out", bus.mem_ena_out, 1);
      check("ur_data_zero", bus.mem_data_out, 8'h00);
      check("ur_flag", underrun, 1);
      check("ur_bytes_left", bytes_left, 3);
      tick(12);
      bus.mem_rd_ena = 1'b1;
      for (int k = 0; k < 3; k++) begin
         logic [7:0] exp;
         tick(1);
         if (k == 2) bus.mem_rd_ena = 1'b0;
         exp = exp_q.pop_front();
         check("ur_b2b_ena", bus.mem_ena_out, 1);
         check("ur_b2b_data", bus.mem_data_out, exp);
      end
      check("ur_int_o_end", int_o, 0);
      check("ur_bytes_left_end", bytes_left, 0);
      check("ur_flag_sticky", underrun, 1);
      flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      check("ur_flag_clr", underrun, 0);

      // lost frame and flag_clr priority
      start_frame(4, 2, 8'h50);
      bus.src_frame_len = LEN_W'(7);
      bus.src_frame_rdy = 1'b1;
      tick(1);
      bus.src_frame_rdy = 1'b0;
      check("lost_flag", frame_lost, 1);
      check("lost_bytes_left", bytes_left, 4);
      check("lost_state", state, FETCH);
      flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      check("lost_clr", frame_lost, 0);
      flag_clr          = 1'b1;
      bus.src_frame_rdy = 1'b1;
      tick(1);
      flag_clr          = 1'b0;
      bus.src_frame_rdy = 1'b0;
      check("lost_clr_priority", frame_lost, 0);
      tick(6);
      read_frame(4, 3);
      check("lost_reqs", req_total - src_base, 4);

      // abort with two requests in flight
      start_frame(20, 8, 8'h60);
      tick(2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      exp_q.delete();
      check("ab_state", state, FLUSH);
      check("ab_int_o", int_o, 0);
      check("ab_bytes_left", bytes_left, 0);
      check("ab_fifo_count", fifo_count, 0);
      check("ab_reqs", req_total - src_base, 2);
      tick(4);
      check("ab_still_flush", state, FLUSH);
      check("ab_reqs_stopped", req_total - src_base, 2);
      for (int i = 0; i < 30 && state != IDLE; i++) tick(1);
      check("ab_idle", state, IDLE);
      check("ab_fifo_empty", fifo_count, 0);
      check("ab_int_o_idle", int_o, 0);
      start_frame(2, 2, 8'h70);
      tick(8);
      read_frame(2, 3);
      check("ab_next_reqs", req_total - src_base, 2);
      check("ab_next_underrun", underrun, 0);

      // zero-length frame, abort in IDLE, read in IDLE
      bus.src_frame_len = '0;
      bus.src_frame_rdy = 1'b1;
      tick(1);
      bus.src_frame_rdy = 1'b0;
      check("zl_state", state, IDLE);
      check("zl_int_o", int_o, 0);
      check("zl_frame_lost", frame_lost, 0);
      check("zl_data_held", bus.mem_data_out, 8'h71);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("idle_abort_state", state, IDLE);
      bus.mem_rd_ena = 1'b1;
      tick(1);
      bus.mem_rd_ena = 1'b0;
      check("idle_rd_ena", bus.mem_ena_out, 1);
      check("idle_rd_data", bus.mem_data_out, 8'h00);
      check("idle_rd_underrun", underrun, 0);
      tick(1);
      check("idle_rd_ena_pulse", bus.mem_ena_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish before 500000");
      $fatal(1);
   end
endmodule

// File: doc/spi_mem_rd_ctrl.md
Name: spi_mem_rd_ctrl

Overview:
Sequences burst reads of demodulated frame data from the byte-source block out through the SPI slave memory-read path. It accepts a frame-ready notification with a byte length, prefetches bytes from the source into a small FIFO under credit control, and serves one byte per SPI mem_rd_ena request. It raises the host interrupt while a frame is pending. It sits between the SPI slave core (mem_rd_ena / mem_data_out / mem_ena_out) and the frame source.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, 2..16
LEN_W, 16, width of the frame byte length and counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
src_frame_rdy  in  1  one-cycle pulse: new frame available
src_frame_len  in  LEN_W  frame byte count, sampled with src_frame_rdy
src_rd_req  out  1  one-cycle pulse per byte requested from source
src_data  in  8  source byte
src_data_vld  in  1  src_data valid; in-order, latency >=1 cycle, one per request
mem_rd_ena  in  1  SPI core requests next byte (one-cycle pulse)
mem_data_out  out  8  byte to SPI core
mem_ena_out  out  1  mem_data_out valid, one cycle
abort  in  1  flush current frame (register-bus strobe)
int_o  out  1  frame pending interrupt, level
bytes_left  out  LEN_W  bytes not yet delivered to SPI
underrun  out  1  sticky: SPI read with FIFO empty during a frame
frame_lost  out  1  sticky: src_frame_rdy received while not IDLE
flag_clr  in  1  clears underrun and frame_lost

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0.
- States: IDLE, FETCH, DRAIN, FLUSH.
- IDLE:
  - src_frame_rdy with len != 0: latch len into fetch_left and bytes_left, go to FETCH, int_o = 1 from the next cycle.
  - len == 0: ignored; no flag set.
- FETCH:
  - Issue src_rd_req when (fifo_count + outstanding) < FIFO_DEPTH and fetch_left != 0.
  - Each request decrements fetch_left and increments outstanding. Each src_data_vld decrements outstanding and pushes the byte into the FIFO.
  - Same-cycle request and response: outstanding unchanged.
  - Go to DRAIN when fetch_left reaches 0.
- DRAIN: no further requests. Go to IDLE when bytes_left == 0 and outstanding == 0.
- SPI service (all states):
  - mem_rd_ena in cycle n: mem_ena_out = 1 in cycle n+1.
  - FIFO non-empty: pop, mem_data_out = head byte, bytes_left decrements.
  - FIFO empty in FETCH/DRAIN: mem_data_out = 8'h00, underrun set, bytes_left unchanged.
  - In IDLE or FLUSH: mem_data_out = 8'h00, no flag.
  - mem_data_out holds its value between strobes.
- int_o: 1 in FETCH/DRAIN, 0 in IDLE/FLUSH. It deasserts the cycle after the last byte pops.
- abort (any non-IDLE state): go to FLUSH and clear the FIFO, fetch_left and bytes_left. Requests stop.
  - FLUSH discards arriving src_data_vld bytes until outstanding == 0, then goes to IDLE.
  - abort in IDLE: no effect.
- src_frame_rdy outside IDLE: ignored, frame_lost set.
- Flag priority: flag_clr has priority over a same-cycle set event.
- Push and pop in the same cycle: both performed; count unchanged. Push is never issued to a full FIFO, which is guaranteed by the credit rule. A src_data_vld arriving with outstanding == 0 is dropped.
- Counters: plain unsigned; no wrap is possible, because a decrement is only issued when the counter is non-zero.
- Reset mid-frame: immediate return to the reset state. The source must be reset by the same reset_n.

Decomposition:
- Shared package (spi_pkg): state encoding constants (IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3), default FIFO_DEPTH, default LEN_W.
- One sub-module: spi_rd_fifo, a synchronous FIFO.
  - Ports: push, pop, flush, din, dout, count.
  - Registered head output; first-word fall-through not required.
  - The controller accounts for the one-cycle pop-to-data timing.

Test Plan:
- Basic frame: len = 5, source latency 2 cycles, bytes 0x11..0x15; SPI reads 5 with 4-cycle spacing -> mem_data_out 0x11..0x15 each one cycle after mem_rd_ena; int_o drops after the 5th; bytes_left 5 -> 0; src_rd_req count = 5.
- Credit limit: FIFO_DEPTH = 4, len = 10, no SPI reads -> exactly 4 src_rd_req, then none; fifo_count = 4; the remaining 6 are fetched as reads proceed.
- Underrun: len = 3, source latency 8, SPI reads back-to-back -> first reply 0x00 with underrun = 1, bytes_left still 3; the frame completes after 3 valid bytes.
- Lost frame: src_frame_rdy in FETCH with len = 7 -> frame_lost = 1, current frame unaffected; flag_clr -> frame_lost = 0.
- Abort: len = 20, abort with 2 requests outstanding -> FLUSH, both late bytes discarded, IDLE after outstanding == 0, int_o = 0, bytes_left = 0; a following frame with len = 2 reads correctly.
- Zero length and idle read: src_frame_rdy with len = 0 -> stays IDLE, int_o = 0; mem_rd_ena in IDLE -> mem_ena_out = 1 with 0x00, no underrun.
